// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
//   valid/ready handshake and a 2-entry buffer: a main register that drives
//   the outputs, and a skid register that absorbs one entry when downstream
//   stalls. in_ready is a flop, so there is no combinational out_ready ->
//   in_ready path.
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         upstream handshake (in_ready registered)
//   in_ctrl/in_data           bundles sampled only on acceptance
//   flush                     synchronous discard of all held entries
//   out_valid/out_ready       downstream handshake
//   out_ctrl/out_data         main register contents (zeroed when idle if ZERO_IDLE)
//   occupancy                 held entries, 0..2
module pipe_stage_elastic #(
  parameter int CTRL_W    = 11,
  parameter int DATA_W    = 64,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  localparam int W = CTRL_W + DATA_W;

  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      // A consume in this cycle has already completed downstream; the
      // accepted-looking input is simply not captured.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      if (ZERO_IDLE) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (skid_vld_q) begin
      // TWO: in_ready_q is 0 here, so only a consume can happen.
      if (consume) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      unique case ({accept, consume})
        2'b11: main_d = {in_ctrl, in_data};
        2'b10: begin
          skid_d     = {in_ctrl, in_data};
          skid_vld_d = 1'b1;
        end
        2'b01: main_vld_d = 1'b0;
        default: ;
      endcase
    end else if (accept) begin
      main_d     = {in_ctrl, in_data};
      main_vld_d = 1'b1;
    end
    // Ready for next cycle is decided from next occupancy only.
    in_ready_d = ~(main_vld_d & skid_vld_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  // Skid is only ever valid alongside main.
  assign occupancy = {skid_vld_q, main_vld_q & ~skid_vld_q};
  assign {out_ctrl, out_data} = (ZERO_IDLE && !main_vld_q) ? '0 : main_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: two instances (ZERO_IDLE=1 and 0, DATA_W=16)
// share one stimulus stream and one expected-entry queue.
module tb_pipe_stage_elastic;
  localparam int CW = 11;
  localparam int DW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy1, ov1, rdy0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;

  int checks   = 0;
  int failures = 0;
  int sink_cnt = 0;

  ent_t q[$];
  logic hold1 = 1'b0, hold0 = 1'b0;
  ent_t prev1, prev0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .ZERO_IDLE(1'b1)) u_z1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1));

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .ZERO_IDLE(1'b0)) u_z0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares both instances against the expected queue, then
  // advances the queue with this cycle's handshakes.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold1 = 1'b0;
      hold0 = 1'b0;
      chk("rst_occ1", 32'(occ1), 32'd0);
      chk("rst_rdy1", 32'(rdy1), 32'd1);
      chk("rst_out1", 32'({oc1, od1}), 32'd0);
      chk("rst_out0", 32'({oc0, od0}), 32'd0);
      chk("rst_ov0", 32'(ov0), 32'd0);
    end else begin
      automatic int sz = q.size();
      chk("occ1", 32'(occ1), 32'(sz));
      chk("occ0", 32'(occ0), 32'(sz));
      chk("ov1", 32'(ov1), 32'(sz != 0));
      chk("ov0", 32'(ov0), 32'(sz != 0));
      chk("rdy1", 32'(rdy1), 32'(sz < 2));
      chk("rdy0", 32'(rdy0), 32'(sz < 2));
      if (sz != 0) begin
        chk("data1", 32'({oc1, od1}), 32'(q[0]));
        chk("data0", 32'({oc0, od0}), 32'(q[0]));
      end else begin
        chk("idle_zero1", 32'({oc1, od1}), 32'd0);
      end
      if (hold1) chk("stable1", 32'({ov1, oc1, od1}), 32'({1'b1, prev1}));
      if (hold0) chk("stable0", 32'({ov0, oc0, od0}), 32'({1'b1, prev0}));
      hold1 = ov1 & ~out_ready & ~flush;
      hold0 = ov0 & ~out_ready & ~flush;
      prev1 = {oc1, od1};
      prev0 = {oc0, od0};
      if (sz != 0 && out_ready) begin
        void'(q.pop_front());
        sink_cnt++;
      end
      if (flush) q.delete();
      else if (in_valid && sz < 2) q.push_back({in_ctrl, in_data});
    end
  end

  task automatic drv(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    rst = 1'b1; in_valid = 0; flush = 0; out_ready = 0; in_ctrl = '0; in_data = '0;
    #2;
    chk("init_ov", 32'(ov1), 32'd0);
    chk("init_rdy", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // T2: 8 back-to-back entries, data=i, ctrl=i+1
    for (int i = 0; i < 8; i++) drv(1'b1, CW'(i + 1), DW'(i), 1'b1, 1'b0);
    chk("t2_last_data", 32'(od1), 32'd7);
    chk("t2_last_ctrl", 32'(oc1), 32'd8);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_drained", 32'(occ1), 32'd0);

    // T3: stall 3 cycles with A, B, C offered; C must be refused
    drv(1'b1, 11'h0A, 16'hAAAA, 1'b0, 1'b0);
    chk("t3_occ_1", 32'(occ1), 32'd1);
    drv(1'b1, 11'h0B, 16'hBBBB, 1'b0, 1'b0);
    chk("t3_occ_2", 32'(occ1), 32'd2);
    chk("t3_rdy_0", 32'(rdy1), 32'd0);
    drv(1'b1, 11'h0C, 16'hCCCC, 1'b0, 1'b0);
    chk("t3_hold_A", 32'(od1), 32'hAAAA);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_then_B", 32'(od1), 32'hBBBB);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_empty", 32'(occ1), 32'd0);

    // T4: flush in TWO with a concurrent input
    drv(1'b1, 11'h011, 16'h1111, 1'b0, 1'b0);
    drv(1'b1, 11'h022, 16'h2222, 1'b0, 1'b0);
    drv(1'b1, 11'h033, 16'h3333, 1'b0, 1'b1);
    chk("t4_occ", 32'(occ1), 32'd0);
    chk("t4_ov", 32'(ov1), 32'd0);
    chk("t4_ctrl", 32'(oc1), 32'd0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_not_delivered", 32'(ov1), 32'd0);

    // T5: flush and consume in ONE
    drv(1'b1, 11'h055, 16'h5555, 1'b0, 1'b0);
    s0 = sink_cnt;
    drv(1'b0, '0, '0, 1'b1, 1'b1);
    chk("t5_sink_once", 32'(sink_cnt), 32'(s0 + 1));
    chk("t5_empty", 32'(occ1), 32'd0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_sink_still", 32'(sink_cnt), 32'(s0 + 1));

    // T1: async reset mid-cycle while in TWO
    drv(1'b1, 11'h066, 16'h6666, 1'b0, 1'b0);
    drv(1'b1, 11'h077, 16'h7777, 1'b0, 1'b0);
    chk("t1_pre_occ", 32'(occ1), 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t1_ov", 32'(ov1), 32'd0);
    chk("t1_occ", 32'(occ1), 32'd0);
    chk("t1_rdy", 32'(rdy1), 32'd1);
    chk("t1_data1", 32'(od1), 32'd0);
    chk("t1_data0", 32'(od0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T6: random traffic, back-pressure and flushes
    for (int i = 0; i < 10000; i++)
      drv(1'($urandom), CW'($urandom), DW'($urandom), 1'($urandom),
          ($urandom_range(15) == 0));
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t6_drained", 32'(occ1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
